// File: rtl/lfsr_prbs_if.sv
// Signal bundle for lfsr_prbs: LFSR control/data, checker inputs and status outputs.
interface lfsr_prbs_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STEP       = 1,
  parameter int unsigned ERR_WIDTH  = 16
);
  logic                  en_i;
  logic                  wr_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [DATA_WIDTH-1:0] poly_i;
  logic                  chk_en_i;
  logic [STEP-1:0]       chk_dat_i;
  logic                  clr_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic [STEP-1:0]       bit_o;
  logic                  zero_o;
  logic                  sync_o;
  logic                  err_o;
  logic [ERR_WIDTH-1:0]  err_cnt_o;

  modport master (
    output en_i, wr_i, dat_i, poly_i, chk_en_i, chk_dat_i, clr_i,
    input  dat_o, bit_o, zero_o, sync_o, err_o, err_cnt_o
  );

  modport slave (
    input  en_i, wr_i, dat_i, poly_i, chk_en_i, chk_dat_i, clr_i,
    output dat_o, bit_o, zero_o, sync_o, err_o, err_cnt_o
  );
endinterface

// File: rtl/lfsr_prbs.sv
// Galois PRBS generator advancing STEP bits per cycle with a run-time polynomial,
// all-zero lock-up recovery, and a loopback checker with HUNT/LOCK sync tracking
// and a saturating bit-error counter.
module lfsr_prbs #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          STEP       = 1,
  parameter logic [DATA_WIDTH-1:0] SEED      = '1,
  parameter int unsigned          SYNC_CNT   = 4,
  parameter int unsigned          LOSS_CNT   = 4,
  parameter int unsigned          ERR_WIDTH  = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  lfsr_prbs_if.slave bus
);

  localparam int unsigned RUN_MAX = (SYNC_CNT > LOSS_CNT) ? SYNC_CNT : LOSS_CNT;
  localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);
  localparam int unsigned POP_W   = $clog2(STEP + 1);
  localparam int unsigned SUM_W   = ERR_WIDTH + POP_W;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } chk_state_e;

  logic [DATA_WIDTH-1:0] q_q, q_d, q_adv;
  logic [STEP-1:0]       bits, mism;
  logic                  zero, cmp, mism_any;
  logic [POP_W-1:0]      pop;
  logic [SUM_W-1:0]      sum;
  chk_state_e            state_q, state_d;
  logic [RUN_W-1:0]      good_q, good_d, bad_q, bad_d;
  logic                  err_q, err_d;
  logic [ERR_WIDTH-1:0]  cnt_q, cnt_d;

  // The top tap bit is implied by the Galois structure, so the mask MSB is unused.
  logic unused_poly_msb;
  assign unused_poly_msb = bus.poly_i[DATA_WIDTH-1];

  // One Galois step: the LSB is emitted, rotated into the MSB and XORed into the taps.
  function automatic logic [DATA_WIDTH-1:0] galois_step(input logic [DATA_WIDTH-1:0] s,
                                                        input logic [DATA_WIDTH-1:0] poly);
    return {s[0], s[DATA_WIDTH-1:1] ^ (poly[DATA_WIDTH-2:0] & {(DATA_WIDTH-1){s[0]}})};
  endfunction

  // Unroll STEP steps from q: collect the emitted bits and the advanced state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    q_adv = q_q;
    bits  = '0;
    for (int unsigned k = 0; k < STEP; k++) begin
      bits[k] = q_adv[0];
      q_adv   = galois_step(q_adv, bus.poly_i);
    end
  end

  assign zero = (q_q == '0);

  // State update: load beats advance; advancing from all-zero restarts at SEED.
  always_comb begin
    q_d = q_q;
    if (bus.wr_i) begin
      q_d = bus.dat_i;
    end else if (bus.en_i) begin
      q_d = zero ? SEED : q_adv;
    end
  end

  // A compare uses the pre-advance bits; all-zero cycles carry no pattern to check.
  assign cmp      = bus.chk_en_i & bus.en_i & ~bus.wr_i & ~zero;
  assign mism     = bus.chk_dat_i ^ bits;
  assign mism_any = |mism;

  // Number of mismatched bits in the current word.
  always_comb begin
    pop = '0;
    for (int unsigned k = 0; k < STEP; k++) begin
      pop = pop + POP_W'(mism[k]);
    end
  end

  assign sum = SUM_W'(cnt_q) + SUM_W'(pop);

  // Checker next-state: HUNT/LOCK run counters, last-word error flag, saturating count.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (!bus.chk_en_i) begin
      state_d = HUNT;
      good_d  = '0;
      bad_d   = '0;
    end else if (cmp) begin
      err_d = mism_any;
      unique case (state_q)
        HUNT: begin
          if (mism_any) begin
            good_d = '0;
          end else if (good_q + RUN_W'(1) == RUN_W'(SYNC_CNT)) begin
            state_d = LOCK;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            good_d = good_q + RUN_W'(1);
          end
        end
        LOCK: begin
          if (sum > SUM_W'({ERR_WIDTH{1'b1}})) begin
            cnt_d = '1;
          end else begin
            cnt_d = sum[ERR_WIDTH-1:0];
          end
          if (!mism_any) begin
            bad_d = '0;
          end else if (bad_q + RUN_W'(1) == RUN_W'(LOSS_CNT)) begin
            state_d = HUNT;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            bad_d = bad_q + RUN_W'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
    if (bus.clr_i) begin
      cnt_d = '0;
    end
  end

  // Registers for the LFSR state and the checker.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (!rst_n_i) begin
      q_q     <= SEED;
      state_q <= HUNT;
      good_q  <= '0;
      bad_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      q_q     <= q_d;
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.dat_o     = q_q;
  assign bus.bit_o     = bits;
  assign bus.zero_o    = zero;
  assign bus.sync_o    = (state_q == LOCK);
  assign bus.err_o     = err_q;
  assign bus.err_cnt_o = cnt_q;

endmodule

// File: tb/tb_lfsr_prbs.sv
// Bench for lfsr_prbs: three 4-bit instances (STEP=1; STEP=2; STEP=2 with a 3-bit
// error counter) share clock, reset and control. A behavioural model feeds a
// scoreboard queue each cycle; tables and hand sequences pin spec-given values.
module tb_lfsr_prbs;
  localparam logic [3:0] SEED = 4'b0001;
  localparam logic [3:0] POLY = 4'b0100;
  localparam int         SYNC = 4;
  localparam int         LOSS = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lfsr_prbs_if #(.DATA_WIDTH(4), .STEP(1), .ERR_WIDTH(16)) if1 ();
  lfsr_prbs_if #(.DATA_WIDTH(4), .STEP(2), .ERR_WIDTH(16)) if2 ();
  lfsr_prbs_if #(.DATA_WIDTH(4), .STEP(2), .ERR_WIDTH(3))  if3 ();

  lfsr_prbs #(.DATA_WIDTH(4), .STEP(1), .SEED(SEED), .SYNC_CNT(SYNC), .LOSS_CNT(LOSS),
              .ERR_WIDTH(16)) u1 (.clk_i(clk), .rst_n_i(rst_n), .bus(if1));
  lfsr_prbs #(.DATA_WIDTH(4), .STEP(2), .SEED(SEED), .SYNC_CNT(SYNC), .LOSS_CNT(LOSS),
              .ERR_WIDTH(16)) u2 (.clk_i(clk), .rst_n_i(rst_n), .bus(if2));
  lfsr_prbs #(.DATA_WIDTH(4), .STEP(2), .SEED(SEED), .SYNC_CNT(SYNC), .LOSS_CNT(LOSS),
              .ERR_WIDTH(3))  u3 (.clk_i(clk), .rst_n_i(rst_n), .bus(if3));

  typedef struct {
    logic [3:0] q;
    logic       lock;
    int         good;
    int         bad;
    logic       err;
    int         cnt;
  } model_t;

  typedef struct {
    int          dut;
    logic [3:0]  dat;
    logic [1:0]  bits;
    logic        zero;
    logic        sync;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic       en;
    logic       wr;
    logic [3:0] dat;
    logic [3:0] q1;
    logic [3:0] q2;
    logic       zero;
  } vec_t;

  model_t m1, m2, m3;
  exp_t   sb[$];
  int     n_pass  = 0;
  int     n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference step written as shift-then-conditional-XOR of the tap word.
  function automatic logic [3:0] m_step(input logic [3:0] s);
    logic [3:0] fb;
    fb = s[0] ? ((POLY & 4'b0111) | 4'b1000) : 4'b0000;
    return (s >> 1) ^ fb;
  endfunction

  function automatic logic [1:0] m_bits(input logic [3:0] s, input int step);
    logic [1:0] b;
    logic [3:0] t;
    b = 2'b00;
    t = s;
    for (int k = 0; k < step; k++) begin
      b[k] = t[0];
      t    = m_step(t);
    end
    return b;
  endfunction

  function automatic model_t m_reset();
    model_t m;
    m.q = SEED; m.lock = 1'b0; m.good = 0; m.bad = 0; m.err = 1'b0; m.cnt = 0;
    return m;
  endfunction

  function automatic model_t m_cycle(input model_t m, input int step, input int cmax,
                                     input logic en, input logic wr, input logic [3:0] dat,
                                     input logic chk_en, input logic [1:0] chk, input logic clr);
    model_t     n;
    logic [3:0] t;
    int         e;
    n = m;
    t = m.q;
    for (int k = 0; k < step; k++) t = m_step(t);
    if (!chk_en) begin
      n.lock = 1'b0; n.good = 0; n.bad = 0;
    end else if (en && !wr && m.q != 4'b0000) begin
      e     = $countones(chk ^ m_bits(m.q, step));
      n.err = (e != 0);
      if (!m.lock) begin
        n.good = (e != 0) ? 0 : m.good + 1;
        if (n.good == SYNC) begin n.lock = 1'b1; n.good = 0; n.bad = 0; end
      end else begin
        n.cnt = (m.cnt + e > cmax) ? cmax : m.cnt + e;
        n.bad = (e != 0) ? m.bad + 1 : 0;
        if (n.bad == LOSS) begin n.lock = 1'b0; n.good = 0; n.bad = 0; end
      end
    end
    if (clr) n.cnt = 0;
    if (wr) n.q = dat;
    else if (en) n.q = (m.q == 4'b0000) ? SEED : t;
    return n;
  endfunction

  function automatic exp_t mk(input int d, input model_t m, input int step);
    exp_t e;
    e.dut = d; e.dat = m.q; e.bits = m_bits(m.q, step); e.zero = (m.q == 4'b0000);
    e.sync = m.lock; e.err = m.err; e.cnt = 16'(m.cnt);
    return e;
  endfunction

  function automatic exp_t act_of(input int d);
    exp_t a;
    a.dut = d;
    case (d)
      0: begin
        a.dat = if1.dat_o; a.bits = {1'b0, if1.bit_o}; a.zero = if1.zero_o;
        a.sync = if1.sync_o; a.err = if1.err_o; a.cnt = if1.err_cnt_o;
      end
      1: begin
        a.dat = if2.dat_o; a.bits = if2.bit_o; a.zero = if2.zero_o;
        a.sync = if2.sync_o; a.err = if2.err_o; a.cnt = if2.err_cnt_o;
      end
      default: begin
        a.dat = if3.dat_o; a.bits = if3.bit_o; a.zero = if3.zero_o;
        a.sync = if3.sync_o; a.err = if3.err_o; a.cnt = {13'b0, if3.err_cnt_o};
      end
    endcase
    return a;
  endfunction

  function automatic vec_t mkv(input logic en, input logic wr, input logic [3:0] dat,
                               input logic [3:0] q1, input logic [3:0] q2, input logic zero);
    vec_t v;
    v.en = en; v.wr = wr; v.dat = dat; v.q1 = q1; v.q2 = q2; v.zero = zero;
    return v;
  endfunction

  // Drive all instances; received words are the model's bits XOR a flip mask.
  task automatic drive(input logic en, input logic wr, input logic [3:0] dat,
                       input logic chk_en, input logic [1:0] flip, input logic clr);
    logic [1:0] b1, b2;
    b1 = m_bits(m1.q, 1);
    b2 = m_bits(m2.q, 2);
    if1.en_i = en; if1.wr_i = wr; if1.dat_i = dat; if1.poly_i = POLY;
    if1.chk_en_i = chk_en; if1.chk_dat_i = b1[0] ^ flip[0]; if1.clr_i = clr;
    if2.en_i = en; if2.wr_i = wr; if2.dat_i = dat; if2.poly_i = POLY;
    if2.chk_en_i = chk_en; if2.chk_dat_i = b2 ^ flip; if2.clr_i = clr;
    if3.en_i = en; if3.wr_i = wr; if3.dat_i = dat; if3.poly_i = POLY;
    if3.chk_en_i = chk_en; if3.chk_dat_i = b2 ^ flip; if3.clr_i = clr;
  endtask

  // One clock: drive, push model expectations, then pop and compare after the edge.
  task automatic cycle(input logic en, input logic wr, input logic [3:0] dat,
                       input logic chk_en, input logic [1:0] flip, input logic clr);
    exp_t e, a;
    drive(en, wr, dat, chk_en, flip, clr);
    m1 = m_cycle(m1, 1, 65535, en, wr, dat, chk_en, {1'b0, if1.chk_dat_i}, clr);
    m2 = m_cycle(m2, 2, 65535, en, wr, dat, chk_en, if2.chk_dat_i, clr);
    m3 = m_cycle(m3, 2, 7, en, wr, dat, chk_en, if3.chk_dat_i, clr);
    sb.push_back(mk(0, m1, 1));
    sb.push_back(mk(1, m2, 2));
    sb.push_back(mk(2, m3, 2));
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = act_of(e.dut);
      check($sformatf("u%0d.dat_o", e.dut + 1), 32'(a.dat), 32'(e.dat));
      check($sformatf("u%0d.bit_o", e.dut + 1), 32'(a.bits), 32'(e.bits));
      check($sformatf("u%0d.zero_o", e.dut + 1), 32'(a.zero), 32'(e.zero));
      check($sformatf("u%0d.sync_o", e.dut + 1), 32'(a.sync), 32'(e.sync));
      check($sformatf("u%0d.err_o", e.dut + 1), 32'(a.err), 32'(e.err));
      check($sformatf("u%0d.err_cnt_o", e.dut + 1), 32'(a.cnt), 32'(e.cnt));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m1 = m_reset(); m2 = m_reset(); m3 = m_reset();
  endtask

  vec_t vt[21];

  initial begin
    m1 = m_reset(); m2 = m_reset(); m3 = m_reset();
    drive(1'b0, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
    do_reset();
    #1;
    check("rst u1.dat_o", 32'(if1.dat_o), 32'(SEED));
    check("rst u2.dat_o", 32'(if2.dat_o), 32'(SEED));
    check("rst u1.bit_o", 32'(if1.bit_o), 32'h1);
    check("rst u2.bit_o", 32'(if2.bit_o), 32'h1);
    check("rst u1.zero_o", 32'(if1.zero_o), 32'h0);
    check("rst u2.sync_o", 32'(if2.sync_o), 32'h0);
    check("rst u2.err_o", 32'(if2.err_o), 32'h0);
    check("rst u2.err_cnt_o", 32'(if2.err_cnt_o), 32'h0);
    check("rst u3.err_cnt_o", 32'(if3.err_cnt_o), 32'h0);

    // Full period (STEP=1 and STEP=2 orbits), then lock-up and load priority rows.
    vt[0]  = mkv(1, 0, 4'h0, 4'b1100, 4'b0110, 0);
    vt[1]  = mkv(1, 0, 4'h0, 4'b0110, 4'b1101, 0);
    vt[2]  = mkv(1, 0, 4'h0, 4'b0011, 4'b0101, 0);
    vt[3]  = mkv(1, 0, 4'h0, 4'b1101, 4'b0111, 0);
    vt[4]  = mkv(1, 0, 4'h0, 4'b1010, 4'b1011, 0);
    vt[5]  = mkv(1, 0, 4'h0, 4'b0101, 4'b1000, 0);
    vt[6]  = mkv(1, 0, 4'h0, 4'b1110, 4'b0010, 0);
    vt[7]  = mkv(1, 0, 4'h0, 4'b0111, 4'b1100, 0);
    vt[8]  = mkv(1, 0, 4'h0, 4'b1111, 4'b0011, 0);
    vt[9]  = mkv(1, 0, 4'h0, 4'b1011, 4'b1010, 0);
    vt[10] = mkv(1, 0, 4'h0, 4'b1001, 4'b1110, 0);
    vt[11] = mkv(1, 0, 4'h0, 4'b1000, 4'b1111, 0);
    vt[12] = mkv(1, 0, 4'h0, 4'b0100, 4'b1001, 0);
    vt[13] = mkv(1, 0, 4'h0, 4'b0010, 4'b0100, 0);
    vt[14] = mkv(1, 0, 4'h0, 4'b0001, 4'b0001, 0);
    vt[15] = mkv(0, 1, 4'h0, 4'b0000, 4'b0000, 1);
    vt[16] = mkv(0, 0, 4'h0, 4'b0000, 4'b0000, 1);
    vt[17] = mkv(1, 0, 4'h0, 4'b0001, 4'b0001, 0);
    vt[18] = mkv(1, 1, 4'h6, 4'b0110, 4'b0110, 0);
    vt[19] = mkv(1, 1, 4'h0, 4'b0000, 4'b0000, 1);
    vt[20] = mkv(1, 0, 4'h0, 4'b0001, 4'b0001, 0);
    for (int i = 0; i < 21; i++) begin
      cycle(vt[i].en, vt[i].wr, vt[i].dat, 1'b0, 2'b00, 1'b0);
      check($sformatf("vec%0d u1.dat_o", i), 32'(if1.dat_o), 32'(vt[i].q1));
      check($sformatf("vec%0d u2.dat_o", i), 32'(if2.dat_o), 32'(vt[i].q2));
      check($sformatf("vec%0d u1.zero_o", i), 32'(if1.zero_o), 32'(vt[i].zero));
    end

    // Loopback: lock exactly on the 4th clean compare.
    repeat (3) cycle(1, 0, 4'h0, 1, 2'b00, 0);
    check("pre-lock u2.sync_o", 32'(if2.sync_o), 32'h0);
    cycle(1, 0, 4'h0, 1, 2'b00, 0);
    check("lock u1.sync_o", 32'(if1.sync_o), 32'h1);
    check("lock u2.sync_o", 32'(if2.sync_o), 32'h1);
    check("lock u2.err_cnt_o", 32'(if2.err_cnt_o), 32'h0);
    cycle(1, 0, 4'h0, 1, 2'b11, 0);
    check("2-bit flip u2.err_cnt_o", 32'(if2.err_cnt_o), 32'h2);
    check("2-bit flip u2.err_o", 32'(if2.err_o), 32'h1);
    check("2-bit flip u2.sync_o", 32'(if2.sync_o), 32'h1);
    cycle(1, 0, 4'h0, 1, 2'b00, 1);
    check("clear u2.err_cnt_o", 32'(if2.err_cnt_o), 32'h0);

    // Loss of sync: 4 inverted words; the dropping word still counts.
    repeat (3) cycle(1, 0, 4'h0, 1, 2'b11, 0);
    check("pre-loss u2.sync_o", 32'(if2.sync_o), 32'h1);
    cycle(1, 0, 4'h0, 1, 2'b11, 0);
    check("loss u2.sync_o", 32'(if2.sync_o), 32'h0);
    check("loss u2.err_cnt_o", 32'(if2.err_cnt_o), 32'h8);
    check("saturate u3.err_cnt_o", 32'(if3.err_cnt_o), 32'h7);
    cycle(1, 0, 4'h0, 1, 2'b11, 0);
    check("hunt no count u2.err_cnt_o", 32'(if2.err_cnt_o), 32'h8);

    // Relock, then clear racing an errored locked compare.
    repeat (4) cycle(1, 0, 4'h0, 1, 2'b00, 0);
    check("relock u2.sync_o", 32'(if2.sync_o), 32'h1);
    cycle(1, 0, 4'h0, 1, 2'b11, 1);
    check("clr wins u2.err_cnt_o", 32'(if2.err_cnt_o), 32'h0);
    check("clr wins u2.err_o", 32'(if2.err_o), 32'h1);
    cycle(1, 0, 4'h0, 1, 2'b01, 0);
    cycle(1, 0, 4'h0, 0, 2'b00, 0);
    check("chk off u2.sync_o", 32'(if2.sync_o), 32'h0);
    check("chk off u2.err_cnt_o", 32'(if2.err_cnt_o), 32'h1);

    // Asynchronous reset in the middle of an errored compare cycle.
    cycle(1, 0, 4'h0, 1, 2'b00, 0);
    drive(1, 0, 4'h0, 1, 2'b11, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst u2.dat_o", 32'(if2.dat_o), 32'(SEED));
    check("async rst u2.err_cnt_o", 32'(if2.err_cnt_o), 32'h0);
    check("async rst u2.err_o", 32'(if2.err_o), 32'h0);
    @(posedge clk);
    #1;
    check("held rst u1.dat_o", 32'(if1.dat_o), 32'(SEED));
    @(negedge clk);
    rst_n = 1'b1;
    m1 = m_reset(); m2 = m_reset(); m3 = m_reset();

    // Mixed random traffic against the model.
    for (int i = 0; i < 80; i++) begin
      logic       r_en, r_wr, r_chk, r_clr;
      logic [3:0] r_dat;
      logic [1:0] r_flip;
      r_en   = ($urandom_range(0, 3) != 0);
      r_wr   = ($urandom_range(0, 15) == 0);
      r_dat  = 4'($urandom_range(0, 15));
      r_chk  = ($urandom_range(0, 19) != 0);
      r_flip = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      r_clr  = ($urandom_range(0, 24) == 0);
      cycle(r_en, r_wr, r_dat, r_chk, r_flip, r_clr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
